// File: rtl/ppu_line_buffer_pkg.sv
// Shared PPU constants for the scanline path.
// LINE_W/ADDR_W/PIX_W size the line buffer; NES_W/NES_H describe the NES
// frame and are also consumed by the composite stage.
package ppu_line_buffer_pkg;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 8;
  localparam int PIX_W  = 6;
  localparam int NES_W  = 256;
  localparam int NES_H  = 240;
endpackage

// File: rtl/ppu_line_ram.sv
// Simple dual-port line RAM, address {bank, ptr}.
// Ports: clk_i; write port we_i/waddr_i/wdata_i (sync write);
//        read port re_i/raddr_i -> rdata_o (registered, holds when re_i==0).
// No reset on storage or read register so it maps onto one block RAM.
module ppu_line_ram
  import ppu_line_buffer_pkg::*;
#(
  parameter int AW = ADDR_W + 1,
  parameter int DW = PIX_W
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ppu_line_buffer.sv
// Ping-pong scanline buffer: the renderer fills one bank while the composite
// stage reads the previously completed line from the other bank.
// Ports:
//   clk_i, rst_ni (sync, active-low)
//   wr_valid_i/wr_ready_o/wr_data_i/wr_last_i : renderer pixel stream
//   rd_line_start_i : pulse, composite stage starts a new NES line
//   rd_en_i/rd_x_i -> rd_valid_o/rd_data_o : registered pixel read
//   rd_hold_o : a completed line is held for reading
//   rd_underflow_o : pulse, line start found no completed line
module ppu_line_buffer
  import ppu_line_buffer_pkg::*;
#(
  parameter int LINE_W = ppu_line_buffer_pkg::LINE_W,
  parameter int ADDR_W = ppu_line_buffer_pkg::ADDR_W,
  parameter int PIX_W  = ppu_line_buffer_pkg::PIX_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic              wr_last_i,
  input  logic              rd_line_start_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_x_i,
  output logic              rd_valid_o,
  output logic [PIX_W-1:0]  rd_data_o,
  output logic              rd_hold_o,
  output logic              rd_underflow_o
);
  logic [1:0]        full_q, full_d;
  logic              wb_q, wb_d, rb_q, rb_d;
  logic              hold_q, hold_d;
  logic              under_q, under_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   len_q [2];
  logic [ADDR_W:0]   len_d [2];
  logic              rd_valid_q;
  logic              rd_sel_q, rd_sel_d;
  logic              wr_acc, wr_done;
  logic [PIX_W-1:0]  ram_rdata;

  assign wr_ready_o = !full_q[wb_q];
  assign wr_acc     = wr_valid_i && wr_ready_o;
  assign wr_done    = wr_acc && (wr_last_i || wr_ptr_q == ADDR_W'(LINE_W - 1));

  // Read mask uses pre-switch state, so a read issued with rd_line_start
  // still sees the outgoing line.
  assign rd_sel_d = hold_q && ({1'b0, rd_x_i} < len_q[rb_q]);

  always_comb begin
    full_d   = full_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    hold_d   = hold_q;
    under_d  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    // Switch looks only at registered full bits: a line completing this
    // same cycle is picked up by the next line start.
    if (rd_line_start_i) begin
      if (hold_q) full_d[rb_q] = 1'b0;
      if (full_q[~rb_q]) begin
        rb_d   = ~rb_q;
        hold_d = 1'b1;
      end else begin
        hold_d  = 1'b0;
        under_d = 1'b1;
      end
    end
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (wr_done) begin
        len_d[wb_q]  = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_ptr_d     = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q     <= '0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b1;
      hold_q     <= 1'b0;
      under_q    <= 1'b0;
      wr_ptr_q   <= '0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      full_q     <= full_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      hold_q     <= hold_d;
      under_q    <= under_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      rd_valid_q <= rd_en_i;
      if (rd_en_i) rd_sel_q <= rd_sel_d;
    end
  end

  ppu_line_ram #(.AW(ADDR_W + 1), .DW(PIX_W)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i ({wb_q, wr_ptr_q}),
    .wdata_i (wr_data_i),
    .re_i    (rd_en_i),
    .raddr_i ({rb_q, rd_x_i}),
    .rdata_o (ram_rdata)
  );

  // Both the RAM register and rd_sel_q hold when rd_en is low, so rd_data holds.
  assign rd_data_o      = rd_sel_q ? ram_rdata : '0;
  assign rd_valid_o     = rd_valid_q;
  assign rd_hold_o      = hold_q;
  assign rd_underflow_o = under_q;

  // A held line keeps its bank full, so the writer can never be completing
  // into the bank being released.
  a_no_bank_clash : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rd_line_start_i && hold_q && wr_done) |-> (rb_q != wb_q));
endmodule

// File: tb/tb_ppu_line_buffer.sv
module tb_ppu_line_buffer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0, wr_last = 1'b0, rd_line_start = 1'b0, rd_en = 1'b0;
  logic [5:0] wr_data = '0;
  logic [7:0] rd_x = '0;
  logic       wr_ready, rd_valid, rd_hold, rd_underflow;
  logic [5:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppu_line_buffer dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_last_i(wr_last),
    .rd_line_start_i(rd_line_start), .rd_en_i(rd_en), .rd_x_i(rd_x),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_hold_o(rd_hold), .rd_underflow_o(rd_underflow)
  );

  // ---------------- behavioural model ----------------
  // Completed-but-unreleased lines live as one pixel stream plus a length list;
  // the held line is a plain array. Capacity is two completed lines in total.
  logic [5:0] pix_q[$];
  int         len_q[$];
  logic [5:0] cur_q[$];
  logic [5:0] held[256];
  int         held_len = 0;
  bit         hold = 0;
  bit         model_init = 0;
  logic       exp_ready = 1'b1, exp_valid = 1'b0, exp_under = 1'b0;
  logic [5:0] exp_data = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      pix_q.delete(); len_q.delete(); cur_q.delete();
      hold = 0; held_len = 0;
      exp_valid = 0; exp_data = 0; exp_under = 0;
      model_init = 1;
    end else begin
      bit pre_ready;
      pre_ready = (len_q.size() + int'(hold)) < 2;
      if (rd_en) exp_data = (hold && int'(rd_x) < held_len) ? held[rd_x] : 6'd0;
      exp_valid = rd_en;
      exp_under = 0;
      if (rd_line_start) begin
        hold = 0;
        if (len_q.size() > 0) begin
          held_len = len_q.pop_front();
          for (int i = 0; i < held_len; i++) held[i] = pix_q.pop_front();
          hold = 1;
        end else exp_under = 1;
      end
      if (wr_valid && pre_ready) begin
        cur_q.push_back(wr_data);
        if (wr_last || cur_q.size() == 256) begin
          len_q.push_back(cur_q.size());
          foreach (cur_q[i]) pix_q.push_back(cur_q[i]);
          cur_q.delete();
        end
      end
    end
    exp_ready = (len_q.size() + int'(hold)) < 2;
  end

  always @(negedge clk) begin
    if (model_init) begin
      checks++;
      if (wr_ready !== exp_ready) begin errors++; $display("FAIL cyc_wr_ready act=%0b exp=%0b t=%0t", wr_ready, exp_ready, $time); end
      checks++;
      if (rd_hold !== hold) begin errors++; $display("FAIL cyc_rd_hold act=%0b exp=%0b t=%0t", rd_hold, hold, $time); end
      checks++;
      if (rd_underflow !== exp_under) begin errors++; $display("FAIL cyc_underflow act=%0b exp=%0b t=%0t", rd_underflow, exp_under, $time); end
      checks++;
      if (rd_valid !== exp_valid) begin errors++; $display("FAIL cyc_rd_valid act=%0b exp=%0b t=%0t", rd_valid, exp_valid, $time); end
      checks++;
      if (rd_data !== exp_data) begin errors++; $display("FAIL cyc_rd_data act=%0d exp=%0d t=%0t", rd_data, exp_data, $time); end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; wr_valid = 0; wr_last = 0; rd_line_start = 0; rd_en = 0;
    tick(); tick();
    check("rst_wr_ready", int'(wr_ready), 1);
    check("rst_rd_hold", int'(rd_hold), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_underflow", int'(rd_underflow), 0);
    rst_n = 1;
  endtask

  // Present one pixel and hold it until accepted (bounded wait).
  task automatic write_px(input logic [5:0] d, input logic last);
    int n = 0;
    wr_valid = 1; wr_data = d; wr_last = last;
    while (!wr_ready && n < 2000) begin tick(); n++; end
    if (n >= 2000) begin errors++; checks++; $display("FAIL wr_timeout act=%0d exp=%0d", n, 0); end
    tick();
  endtask

  task automatic write_line(input int n, input int base, input bit use_last);
    for (int i = 0; i < n; i++) write_px(6'(base + i), use_last && (i == n - 1));
    wr_valid = 0; wr_last = 0;
  endtask

  task automatic pulse_start();
    rd_line_start = 1; tick(); rd_line_start = 0;
  endtask

  task automatic read_chk(input string name, input int x, input int exp);
    rd_en = 1; rd_x = 8'(x); tick(); rd_en = 0;
    check({name, "_valid"}, int'(rd_valid), 1);
    check(name, int'(rd_data), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=%0t exp=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Full line, read back three addresses.
    do_reset();
    write_line(256, 0, 0);
    pulse_start();
    check("t1_hold", int'(rd_hold), 1);
    read_chk("t1_x0", 0, 0);
    read_chk("t1_x5", 5, 5);
    read_chk("t1_x255", 255, 63);

    // Both banks full, then drain one.
    do_reset();
    write_line(256, 0, 0);
    write_line(256, 7, 0);
    check("t2_full_ready", int'(wr_ready), 0);
    pulse_start();
    check("t2_p1_hold", int'(rd_hold), 1);
    check("t2_p1_ready", int'(wr_ready), 0);
    pulse_start();
    check("t2_p2_ready", int'(wr_ready), 1);
    read_chk("t2_bank1_x3", 3, 10);

    // Underflow straight after reset.
    do_reset();
    pulse_start();
    check("t3_under", int'(rd_underflow), 1);
    check("t3_hold", int'(rd_hold), 0);
    tick();
    check("t3_under_drop", int'(rd_underflow), 0);
    read_chk("t3_x0", 0, 0);

    // Short line ends early.
    do_reset();
    write_line(100, 20, 1);
    pulse_start();
    read_chk("t4_x99", 99, 55);
    read_chk("t4_x100", 100, 0);
    read_chk("t4_x200", 200, 0);

    // Line completing together with line start is invisible to that switch.
    do_reset();
    write_line(255, 0, 0);
    wr_valid = 1; wr_data = 6'd63; wr_last = 0; rd_line_start = 1;
    tick();
    wr_valid = 0; rd_line_start = 0;
    check("t5_under", int'(rd_underflow), 1);
    check("t5_hold0", int'(rd_hold), 0);
    pulse_start();
    check("t5_hold1", int'(rd_hold), 1);
    read_chk("t5_x255", 255, 63);

    // Reset mid-line discards the partial line.
    do_reset();
    write_line(50, 9, 0);
    do_reset();
    write_line(256, 33, 0);
    pulse_start();
    read_chk("t6_x0", 0, 33);

    // Randomised traffic against the model.
    do_reset();
    begin
      bit acc = 0;
      for (int c = 0; c < 4000; c++) begin
        if (!wr_valid || acc) begin
          wr_valid = ($urandom_range(0, 3) != 0);
          wr_data  = 6'($urandom);
          wr_last  = ($urandom_range(0, 40) == 0);
        end
        rd_line_start = ($urandom_range(0, 80) == 0);
        rd_en = 1'($urandom);
        rd_x  = 8'($urandom);
        acc = wr_valid && wr_ready;
        tick();
      end
      wr_valid = 0; rd_line_start = 0; rd_en = 0;
      tick(); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
